// File: rtl/pattern_det_prog.sv
// Runtime-programmable serial pattern detector (1..MAX_LEN bits, overlapping or not).
// Optional sticky dropped-beat flag err_o when PATTERN_DET_PROG_ERR_EN is defined.
module pattern_det_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_1010,
  parameter int                 DEF_LEN     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_i,
  input  logic               valid_i,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               pattern,
  output logic [CNT_W-1:0]   match_cnt
`ifdef PATTERN_DET_PROG_ERR_EN
  ,
  output logic               err_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_FILL = 3'b010,
    S_HUNT = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] sr_q, sr_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic               pattern_q;

  logic [LEN_W-1:0]   len_clamp_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [MAX_LEN-1:0] sr_shift_s;
  logic [LEN_W:0]     fill_inc_s;
  logic               beat_s;
  logic               hit_s;
  logic               match_s;

  // Next-state, shift/fill and match evaluation on the post-shift window
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    match_s     = 1'b0;
    len_clamp_s = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_W'(i) < len_q);
    end
    beat_s     = valid_i & ~cfg_we;
    sr_shift_s = {sr_q[MAX_LEN-2:0], d_i};
    fill_inc_s = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
    hit_s      = ((sr_shift_s & mask_s) == (pat_q & mask_s)) &&
                 (fill_inc_s >= {1'b0, len_q});

    if (cfg_we) begin
      sr_d    = '0;
      fill_d  = '0;
      state_d = (len_clamp_s == '0) ? S_IDLE : S_FILL;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_FILL, S_HUNT: begin
          if (beat_s) begin
            sr_d    = sr_shift_s;
            match_s = hit_s;
            if (hit_s && !overlap_q) begin
              fill_d  = '0;
              state_d = S_FILL;
            end else if (fill_inc_s >= {1'b0, len_q}) begin
              fill_d  = len_q;
              state_d = S_HUNT;
            end else begin
              fill_d  = fill_inc_s[LEN_W-1:0];
              state_d = S_FILL;
            end
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = S_FILL;
          sr_d    = '0;
          fill_d  = '0;
        end
      endcase
    end

    if (cfg_we) begin
      cnt_d = '0;
    end else if (match_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, datapath and configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (DEF_LEN == 0) ? S_IDLE : S_FILL;
      sr_q      <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      pattern_q <= 1'b0;
      pat_q     <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      pattern_q <= match_s;
      if (cfg_we) begin
        pat_q     <= cfg_pattern;
        len_q     <= len_clamp_s;
        overlap_q <= cfg_overlap;
      end else begin
        pat_q     <= pat_q;
        len_q     <= len_q;
        overlap_q <= overlap_q;
      end
    end
  end

  assign pattern   = pattern_q;
  assign match_cnt = cnt_q;

`ifdef PATTERN_DET_PROG_ERR_EN
  logic err_q;

  // Sticky flag for a beat dropped by a concurrent configuration write
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (valid_i && cfg_we) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err_o = err_q;
`endif

endmodule
